// File: rtl/bsg_cgol_pkg.sv
// ---------------------------------------------------------------------------
// bsg_cgol_pkg
//
// Shared definitions for the Game-of-Life controller and the board wrapper
// that places the controller next to its cell array.
//
// Contents:
//   cgol_state_e  - controller FSM states (eIdle, eLoad, eBusy, eDone)
//   frame_width() - bit width needed to hold a frame count 0..max_game_length
// ---------------------------------------------------------------------------
package bsg_cgol_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        eIdle = 2'd0,
        eLoad = 2'd1,
        eBusy = 2'd2,
        eDone = 2'd3
    } cgol_state_e;

    // Width of a frame counter able to represent 0..max_game_length.
    // Never returns less than one bit so a degenerate maximum of zero still
    // produces a legal vector.
    function automatic int frame_width(input int max_game_length);
        int w;
        w = $clog2(max_game_length + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bsg_cgol_frame_counter.sv
// ---------------------------------------------------------------------------
// bsg_cgol_frame_counter
//
// Loadable, clamping down-counter that tracks how many generations are still
// to be simulated.
//
// Ports:
//   clk_i      - clock, rising edge
//   reset_n_i  - asynchronous active-low reset, clears the count
//   load_i     - load val_i (clamped to max_val_p) into the counter
//   val_i      - requested frame count
//   dec_i      - decrement by one (ignored at zero, load has priority)
//   zero_o     - count is zero
//   one_o      - count is one (last generation in progress)
// ---------------------------------------------------------------------------
module bsg_cgol_frame_counter #(
    parameter int width_p   = 10,
    parameter int max_val_p = 1000
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] val_i,
    input  logic               dec_i,
    output logic               zero_o,
    output logic               one_o
);

    localparam logic [width_p-1:0] max_val_lp = width_p'(max_val_p);
    localparam logic [width_p-1:0] one_lp     = width_p'(1);

    logic [width_p-1:0] count_r;
    logic [width_p-1:0] clamped;

    // Requests beyond the largest supported game are cut down to it at load
    // time, so the rest of the controller never sees an oversized count.
    assign clamped = (val_i > max_val_lp) ? max_val_lp : val_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (load_i) begin
            count_r <= clamped;
        end else if (dec_i && (count_r != '0)) begin
            count_r <= count_r - one_lp;
        end
    end

    assign zero_o = (count_r == '0);
    assign one_o  = (count_r == one_lp);

endmodule

// File: rtl/bsg_cgol.sv
// ---------------------------------------------------------------------------
// bsg_cgol_ctrl
//
// Controller for a board_width_p x board_width_p Game-of-Life cell array.
// Accepts an initial board plus a generation count, loads the board into the
// cells, enables exactly that many generations, then presents the final
// board until downstream consumes it. The cells themselves live outside
// this block.
//
// Ports:
//   clk_i        - clock, rising edge
//   reset_n_i    - asynchronous active-low reset
//   v_i          - upstream offers a game (board + frame count)
//   data_i       - initial board, bit r*board_width_p+c = cell (r,c)
//   frames_i     - generations to simulate (clamped to max_game_length_p)
//   ready_o      - controller can accept a game
//   update_o     - load update_val_o into every cell
//   update_val_o - captured initial board, one bit per cell
//   en_o         - advance every cell by one generation
//   cells_i      - current state of every cell
//   v_o          - final board valid
//   data_o       - final board
//   yumi_i       - downstream consumes data_o
// ---------------------------------------------------------------------------
module bsg_cgol_ctrl
    import bsg_cgol_pkg::*;
#(
    parameter int board_width_p     = 8,
    parameter int max_game_length_p = 1000
) (
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic                                         v_i,
    input  logic [board_width_p*board_width_p-1:0]       data_i,
    input  logic [frame_width(max_game_length_p)-1:0]    frames_i,
    output logic                                         ready_o,
    output logic                                         update_o,
    output logic [board_width_p*board_width_p-1:0]       update_val_o,
    output logic                                         en_o,
    input  logic [board_width_p*board_width_p-1:0]       cells_i,
    output logic                                         v_o,
    output logic [board_width_p*board_width_p-1:0]       data_o,
    input  logic                                         yumi_i
);

    localparam int frame_width_lp = frame_width(max_game_length_p);

    cgol_state_e state_r;
    cgol_state_e state_n;

    logic capture;
    logic dec;
    logic frames_zero;
    logic frames_one;

    // Remaining-generation counter, loaded on the accepting handshake and
    // stepped once per enabled generation.
    bsg_cgol_frame_counter #(
        .width_p   (frame_width_lp),
        .max_val_p (max_game_length_p)
    ) frame_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (capture),
        .val_i     (frames_i),
        .dec_i     (dec),
        .zero_o    (frames_zero),
        .one_o     (frames_one)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= eIdle;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and control outputs. Every control output depends only on
    // the registered state, so the cell array sees glitch-free broadcasts.
    // Only the internal capture strobe looks at v_i.
    always_comb begin
        state_n  = state_r;
        ready_o  = 1'b0;
        update_o = 1'b0;
        en_o     = 1'b0;
        v_o      = 1'b0;
        capture  = 1'b0;
        dec      = 1'b0;
        case (state_r)
            eIdle: begin
                ready_o = 1'b1;
                if (v_i) begin
                    capture = 1'b1;
                    state_n = eLoad;
                end
            end
            eLoad: begin
                update_o = 1'b1;
                state_n  = frames_zero ? eDone : eBusy;
            end
            eBusy: begin
                // The cycle that sees a count of one runs the final
                // generation, giving exactly frames_i enabled cycles.
                en_o = 1'b1;
                dec  = 1'b1;
                if (frames_one) begin
                    state_n = eDone;
                end
            end
            eDone: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_n = eIdle;
                end
            end
            default: begin
                state_n = eIdle;
            end
        endcase
    end

    // Initial board is held from one capture to the next so the cells can be
    // reloaded from it during eLoad.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            update_val_o <= '0;
        end else if (capture) begin
            update_val_o <= data_i;
        end
    end

    // The cells hold still outside eBusy, so their outputs are the result.
    assign data_o = cells_i;

endmodule
